// File: rtl/vm_change_dispenser.sv
// Coin-return back end: pays out a requested rupee amount from 2- and 1-rupee
// hopper tubes, one coin per eject strobe, waiting for a hopper ack after each coin.
// Ports: clk/rst (sync, active-high); req+amount start a payout, refill reloads stock
// (both only in IDLE); hop_ack confirms a dropped coin; ej1/ej2 eject strobes;
// busy/done/err status; cnt1/cnt2 remaining inventory.
module vm_change_dispenser #(
  parameter int AMT_W     = 4,
  parameter int CNT_W     = 6,
  parameter int INIT_C1   = 20,
  parameter int INIT_C2   = 20,
  parameter int PULSE_LEN = 2,
  parameter int ACK_TMO   = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [AMT_W-1:0] amount,
  input  logic             refill,
  input  logic             hop_ack,
  output logic             ej1,
  output logic             ej2,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_EJECT,
    S_WAIT_ACK,
    S_DONE,
    S_ERR
  } state_t;

  // Wide enough that rem, 2*n2 and the counters never wrap in the feasibility math.
  localparam int CW = AMT_W + CNT_W + 1;
  localparam int PW = $clog2(PULSE_LEN + 1);
  localparam int TW = $clog2(ACK_TMO + 1);

  state_t           state;
  logic [AMT_W-1:0] rem;
  logic             coin2;  // coin currently being paid out is a 2-rupee coin
  logic [PW-1:0]    pcnt;
  logic [TW-1:0]    tmo;

  // Feasibility: take as many 2s as possible, then the remainder must fit in 1s.
  logic [CW-1:0] rem_w, c1_w, c2_w, half_w, n2_w, left_w;
  logic          feasible;

  always_comb begin
    rem_w    = CW'(rem);
    c1_w     = CW'(cnt1);
    c2_w     = CW'(cnt2);
    half_w   = rem_w >> 1;
    n2_w     = (half_w < c2_w) ? half_w : c2_w;
    left_w   = rem_w - (n2_w << 1);
    feasible = (left_w <= c1_w);
  end

  // Values after the current coin is acknowledged; the next coin choice is made
  // from these so the next strobe can be registered on the ack edge.
  logic [AMT_W-1:0] rem_after;
  logic [CNT_W-1:0] cnt1_after, cnt2_after;
  logic             pick2_now, pick2_after;

  always_comb begin
    rem_after   = rem - (coin2 ? AMT_W'(2) : AMT_W'(1));
    cnt1_after  = coin2 ? cnt1 : cnt1 - CNT_W'(1);
    cnt2_after  = coin2 ? cnt2 - CNT_W'(1) : cnt2;
    pick2_now   = (rem >= AMT_W'(2)) && (cnt2 != '0);
    pick2_after = (rem_after >= AMT_W'(2)) && (cnt2_after != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      rem   <= '0;
      coin2 <= 1'b0;
      pcnt  <= '0;
      tmo   <= '0;
      ej1   <= 1'b0;
      ej2   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      cnt1  <= CNT_W'(INIT_C1);
      cnt2  <= CNT_W'(INIT_C2);
    end else begin
      case (state)
        S_IDLE: begin
          if (refill) begin
            cnt1 <= CNT_W'(INIT_C1);
            cnt2 <= CNT_W'(INIT_C2);
          end
          if (req) begin
            rem   <= amount;
            busy  <= 1'b1;
            state <= S_CHECK;
          end
        end

        S_CHECK: begin
          if (rem == '0) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else if (!feasible) begin
            err   <= 1'b1;
            state <= S_ERR;
          end else begin
            coin2 <= pick2_now;
            ej2   <= pick2_now;
            ej1   <= !pick2_now;
            pcnt  <= '0;
            state <= S_EJECT;
          end
        end

        S_EJECT: begin
          if (pcnt == PW'(PULSE_LEN - 1)) begin
            ej1   <= 1'b0;
            ej2   <= 1'b0;
            tmo   <= '0;
            state <= S_WAIT_ACK;
          end else begin
            pcnt <= pcnt + PW'(1);
          end
        end

        S_WAIT_ACK: begin
          if (hop_ack) begin
            rem  <= rem_after;
            cnt1 <= cnt1_after;
            cnt2 <= cnt2_after;
            if (rem_after == '0) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              coin2 <= pick2_after;
              ej2   <= pick2_after;
              ej1   <= !pick2_after;
              pcnt  <= '0;
              state <= S_EJECT;
            end
          end else if (tmo == TW'(ACK_TMO - 1)) begin
            // Partial payout stays reflected in rem and the counters.
            err   <= 1'b1;
            state <= S_ERR;
          end else begin
            tmo <= tmo + TW'(1);
          end
        end

        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        S_ERR: begin
          err   <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          ej1   <= 1'b0;
          ej2   <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
          err   <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vm_change_dispenser.sv
// Directed bench for vm_change_dispenser: instance a uses default stock (20/20),
// instance b uses a 1/1 stock for the shortage cases.
module tb_vm_change_dispenser;

  logic       clk;
  logic       rst;

  logic       a_req, a_refill, a_hop_ack;
  logic [3:0] a_amount;
  logic       a_ej1, a_ej2, a_busy, a_done, a_err;
  logic [5:0] a_cnt1, a_cnt2;

  logic       b_req, b_refill, b_hop_ack;
  logic [3:0] b_amount;
  logic       b_ej1, b_ej2, b_busy, b_done, b_err;
  logic [5:0] b_cnt1, b_cnt2;

  int checks;
  int failures;

  vm_change_dispenser dut_a (
    .clk(clk), .rst(rst), .req(a_req), .amount(a_amount), .refill(a_refill),
    .hop_ack(a_hop_ack), .ej1(a_ej1), .ej2(a_ej2), .busy(a_busy), .done(a_done),
    .err(a_err), .cnt1(a_cnt1), .cnt2(a_cnt2)
  );

  vm_change_dispenser #(.INIT_C1(1), .INIT_C2(1)) dut_b (
    .clk(clk), .rst(rst), .req(b_req), .amount(b_amount), .refill(b_refill),
    .hop_ack(b_hop_ack), .ej1(b_ej1), .ej2(b_ej2), .busy(b_busy), .done(b_done),
    .err(b_err), .cnt1(b_cnt1), .cnt2(b_cnt2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Pulse req (optionally with refill) for one cycle; returns at the first
  // negedge after the CHECK cycle.
  task automatic issue_req(input bit sel, input logic [3:0] amt, input bit rf, input string tag);
    if (sel) begin
      b_req = 1'b1; b_amount = amt; b_refill = rf;
    end else begin
      a_req = 1'b1; a_amount = amt; a_refill = rf;
    end
    step();
    a_req = 1'b0; a_refill = 1'b0;
    b_req = 1'b0; b_refill = 1'b0;
    chk({tag, "_check_busy"}, sel ? b_busy : a_busy, 1);
    chk({tag, "_check_ej"}, sel ? {b_ej1, b_ej2} : {a_ej1, a_ej2}, 0);
    step();
  endtask

  // Expect one coin strobe held for two cycles, then WAIT_ACK; optionally ack.
  task automatic expect_coin(input bit sel, input string tag, input bit e2, input bit ack);
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_ej1"}, sel ? b_ej1 : a_ej1, {31'd0, !e2});
      chk({tag, "_ej2"}, sel ? b_ej2 : a_ej2, {31'd0, e2});
      step();
    end
    chk({tag, "_wait_ej"}, sel ? {b_ej1, b_ej2} : {a_ej1, a_ej2}, 0);
    chk({tag, "_wait_busy"}, sel ? b_busy : a_busy, 1);
    if (ack) begin
      if (sel) b_hop_ack = 1'b1;
      else     a_hop_ack = 1'b1;
      step();
      a_hop_ack = 1'b0;
      b_hop_ack = 1'b0;
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    a_req = 1'b0; a_refill = 1'b0; a_hop_ack = 1'b0; a_amount = '0;
    b_req = 1'b0; b_refill = 1'b0; b_hop_ack = 1'b0; b_amount = '0;

    // 1: reset state
    step();
    step();
    rst = 1'b0;
    chk("rst_cnt1", a_cnt1, 20);
    chk("rst_cnt2", a_cnt2, 20);
    chk("rst_outs", {a_ej1, a_ej2, a_busy, a_done, a_err}, 0);
    chk("rst_b_cnt", {b_cnt1, b_cnt2}, {6'd1, 6'd1});

    // 2: amount 5 -> 2, 2, 1
    issue_req(0, 4'd5, 0, "t2");
    expect_coin(0, "t2_c1", 1, 1);
    chk("t2_cnt2_a", a_cnt2, 19);
    expect_coin(0, "t2_c2", 1, 1);
    chk("t2_cnt2_b", a_cnt2, 18);
    expect_coin(0, "t2_c3", 0, 1);
    chk("t2_done", a_done, 1);
    chk("t2_done_busy", a_busy, 1);
    chk("t2_cnt1", a_cnt1, 19);
    chk("t2_cnt2", a_cnt2, 18);
    step();
    chk("t2_done_end", a_done, 0);
    chk("t2_busy_end", a_busy, 0);

    // 3: short stock (1/1): amount 4 infeasible, amount 3 ok
    issue_req(1, 4'd4, 0, "t3a");
    chk("t3a_err", b_err, 1);
    chk("t3a_no_strobe", {b_ej1, b_ej2, b_done}, 0);
    chk("t3a_cnt", {b_cnt1, b_cnt2}, {6'd1, 6'd1});
    step();
    chk("t3a_err_end", {b_err, b_busy}, 0);
    issue_req(1, 4'd3, 0, "t3b");
    expect_coin(1, "t3b_c1", 1, 1);
    expect_coin(1, "t3b_c2", 0, 1);
    chk("t3b_done", b_done, 1);
    chk("t3b_cnt", {b_cnt1, b_cnt2}, 0);
    step();
    chk("t3b_done_end", {b_done, b_busy}, 0);
    // refill with req on an empty machine: CHECK must see the refilled stock
    issue_req(1, 4'd2, 1, "t3c");
    expect_coin(1, "t3c_c1", 1, 1);
    chk("t3c_done", b_done, 1);
    chk("t3c_cnt", {b_cnt1, b_cnt2}, {6'd1, 6'd0});
    step();

    // 4: ack timeout after 15 cycles in WAIT_ACK
    issue_req(0, 4'd2, 0, "t4");
    expect_coin(0, "t4_c1", 1, 0);
    for (int w = 2; w <= 15; w++) begin
      step();
      chk($sformatf("t4_wait%0d_err", w), {a_err, a_ej1, a_ej2}, 0);
    end
    step();
    chk("t4_err", a_err, 1);
    chk("t4_cnt2", a_cnt2, 18);
    chk("t4_cnt1", a_cnt1, 19);
    chk("t4_no_done", a_done, 0);
    step();
    chk("t4_err_end", {a_err, a_busy}, 0);

    // 5: amount 0, plus req(7) held through the busy cycles
    a_req = 1'b1; a_amount = 4'd0;
    step();
    chk("t5_check_busy", a_busy, 1);
    chk("t5_check_done", a_done, 0);
    a_amount = 4'd7;
    step();
    chk("t5_done", a_done, 1);
    chk("t5_no_strobe", {a_ej1, a_ej2}, 0);
    step();
    a_req = 1'b0;
    chk("t5_idle", {a_done, a_busy}, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("t5_ignored%0d", k), {a_busy, a_ej1, a_ej2}, 0);
    end
    chk("t5_cnt", {a_cnt1, a_cnt2}, {6'd19, 6'd18});

    // 6: reset during WAIT_ACK, then refill+req together
    issue_req(0, 4'd4, 0, "t6");
    expect_coin(0, "t6_c1", 1, 1);
    chk("t6_cnt2_mid", a_cnt2, 17);
    expect_coin(0, "t6_c2", 1, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_rst_outs", {a_busy, a_done, a_err, a_ej1, a_ej2}, 0);
    chk("t6_rst_cnt2", a_cnt2, 20);
    chk("t6_rst_cnt1", a_cnt1, 20);
    step();
    chk("t6_no_pulse", {a_done, a_err, a_busy}, 0);
    issue_req(0, 4'd1, 1, "t6r");
    expect_coin(0, "t6r_c1", 0, 1);
    chk("t6r_done", a_done, 1);
    chk("t6r_cnt1", a_cnt1, 19);
    chk("t6r_cnt2", a_cnt2, 20);
    step();
    chk("t6r_end", {a_done, a_busy}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
